// File: rtl/reorder_buffer.sv
// Reorder buffer: accepts (data, addr) beats out of order within a DEPTH-address window
// and emits them in ascending address order. Optional head-skip timeout: REORDER_TIMEOUT_EN.
module reorder_buffer #(
  parameter int              DATA_W     = 24,
  parameter int              ADDR_W     = 20,
  parameter int              DEPTH      = 16,
  parameter int              TIMEOUT    = 1024,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_skip,
  output logic                       err_late,
  output logic                       err_dup,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("reorder_buffer: DEPTH must be a power of two in 2..256 and TIMEOUT >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [ADDR_W-1:0] exp_addr_reg;
  logic [OCC_W-1:0]  occ_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic              out_valid_reg;
  logic              out_skip_reg;
  logic              err_late_reg;
  logic              err_dup_reg;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  in_slot;
  logic [IDX_W-1:0]  head_slot;
  logic              in_window;
  logic              behind;
  logic              accept;
  logic              store_ok;
  logic              is_dup;
  logic              is_late;
  logic              bypass;
  logic              head_ram;
  logic              can_load;
  logic              load_ram;
  logic              load_byp;
  logic              skip_load;
  logic              load;
  logic              ram_write;

  // Modular distance from the next address to emit; the upper half means "behind".
  assign off       = in_addr - exp_addr_reg;
  assign in_window = (off < ADDR_W'(DEPTH));
  assign behind    = off[ADDR_W-1];
  assign in_slot   = in_addr[IDX_W-1:0];
  assign head_slot = exp_addr_reg[IDX_W-1:0];

  assign in_ready  = !clear && (in_window || behind);
  assign accept    = in_valid && in_ready;
  assign store_ok  = accept && in_window && !valid_reg[in_slot];
  assign is_dup    = accept && in_window && valid_reg[in_slot];
  assign is_late   = accept && behind;
  assign bypass    = store_ok && (off == '0);

  assign head_ram  = valid_reg[head_slot];
  assign can_load  = !out_valid_reg || out_ready;
  assign load_ram  = can_load && head_ram;
  assign load_byp  = can_load && bypass;
  assign load      = load_ram || load_byp || skip_load;
  // A head beat that cannot go straight to the output register parks in RAM.
  assign ram_write = store_ok && !load_byp;

`ifdef REORDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            stall;

  assign stall     = can_load && !head_ram && !bypass && (occ_reg != '0);
  assign skip_load = stall && (to_cnt_reg == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (clear || load) begin
      to_cnt_reg <= '0;
    end else if (stall) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end
`else
  assign skip_load = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (ram_write) begin
      mem[in_slot] <= in_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
        end else if (clear) begin
          valid_reg[gi] <= 1'b0;
        end else if (ram_write && in_slot == IDX_W'(gi)) begin
          valid_reg[gi] <= 1'b1;
        end else if (load_ram && head_slot == IDX_W'(gi)) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_addr_reg  <= '0;
      occ_reg       <= '0;
      out_data_reg  <= '0;
      out_addr_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_skip_reg  <= 1'b0;
      err_late_reg  <= 1'b0;
      err_dup_reg   <= 1'b0;
    end else if (clear) begin
      exp_addr_reg  <= '0;
      occ_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_skip_reg  <= 1'b0;
      err_late_reg  <= 1'b0;
      err_dup_reg   <= 1'b0;
    end else begin
      err_late_reg <= is_late;
      err_dup_reg  <= is_dup;
      occ_reg      <= occ_reg + OCC_W'(ram_write) - OCC_W'(load_ram);
      if (load) begin
        out_valid_reg <= 1'b1;
        out_addr_reg  <= exp_addr_reg;
        out_skip_reg  <= skip_load;
        out_data_reg  <= skip_load ? FILL_VALUE : (load_byp ? in_data : mem[head_slot]);
        exp_addr_reg  <= exp_addr_reg + ADDR_W'(1);
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_addr  = out_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_skip  = out_skip_reg;
  assign err_late  = err_late_reg;
  assign err_dup   = err_dup_reg;
  assign occupancy = occ_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table, directed corner sequences and
// randomized traffic against an address-keyed reference model.
module tb_reorder_buffer;

  localparam int              DW   = 24;
  localparam int              AW   = 8;
  localparam int              DP   = 16;
  localparam int              TO   = 8;
  localparam logic [DW-1:0]   FILL = 24'hABCDEF;
  localparam int              AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          out_skip;
  logic          err_late;
  logic          err_dup;
  logic [$clog2(DP):0] occupancy;

  reorder_buffer #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO), .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_addr(in_addr), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_skip(out_skip), .err_late(err_late), .err_dup(err_dup), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending beats keyed by full address, plus the output register.
  logic [DW-1:0] pend [int];
  int            m_exp  = 0;
  bit            m_ov   = 0;
  bit            m_skip = 0;
  bit            m_late = 0;
  bit            m_dup  = 0;
  int            m_oa   = 0;
  logic [DW-1:0] m_od   = '0;
  int            m_to   = 0;
  bit            last_rdy;
  int            late_seen = 0;
  int            dup_seen  = 0;

  typedef struct {
    bit v; int a; bit ordy; bit clr;
    bit e_rdy; bit e_ov; int e_oa; int e_occ;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string name, longint act, longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic bit m_ready(int a, bit clr);
    int off;
    off = (a - m_exp) & (AMOD - 1);
    return !clr && (off < DP || off >= AMOD / 2);
  endfunction

  task automatic cycle(bit v, int a_in, bit ordy, bit clr);
    logic [DW-1:0] d;
    bit r, can;
    int a, off, pre_size;
    a = a_in & (AMOD - 1);
    @(negedge clk);
    d = DW'($urandom());
    in_valid = v; in_addr = AW'(a); in_data = d; out_ready = ordy; clear = clr;
    #1;
    r = m_ready(a, clr);
    chk("in_ready", in_ready, r);
    last_rdy = in_ready;
    @(posedge clk);
    if (clr) begin
      pend.delete();
      m_exp = 0; m_ov = 0; m_skip = 0; m_late = 0; m_dup = 0; m_to = 0;
    end else begin
      m_late = 0; m_dup = 0;
      pre_size = pend.size();
      off = (a - m_exp) & (AMOD - 1);
      if (v && r) begin
        if (off >= AMOD / 2) m_late = 1;
        else if (pend.exists(a)) m_dup = 1;
        else pend[a] = d;
      end
      can = !m_ov || ordy;
      if (can && pend.exists(m_exp)) begin
        m_od = pend[m_exp]; pend.delete(m_exp);
        m_oa = m_exp; m_ov = 1; m_skip = 0; m_to = 0;
        m_exp = (m_exp + 1) % AMOD;
      end
`ifdef REORDER_TIMEOUT_EN
      else if (can && pre_size > 0 && m_to == TO) begin
        m_od = FILL; m_oa = m_exp; m_ov = 1; m_skip = 1; m_to = 0;
        m_exp = (m_exp + 1) % AMOD;
      end else if (can && pre_size > 0) begin
        m_to++; m_ov = 0;
      end
`endif
      else if (can) begin
        m_ov = 0;
      end
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_addr", out_addr, m_oa);
      chk("out_data", out_data, m_od);
      chk("out_skip", out_skip, m_skip);
    end
    chk("occupancy", occupancy, pend.size());
    chk("err_late", err_late, m_late);
    chk("err_dup", err_dup, m_dup);
    if (err_late) late_seen++;
    if (err_dup) dup_seen++;
    if (pre_size < 0) $display("unreachable");
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 0, ordy, 0);
  endtask

  initial begin
    // Out-of-order burst 3,1,2,0: outputs start the cycle after addr 0, occupancy peaks at 3.
    tbl[0] = '{1, 3, 1, 0, 1, 0, 0, 1};
    tbl[1] = '{1, 1, 1, 0, 1, 0, 0, 2};
    tbl[2] = '{1, 2, 1, 0, 1, 0, 0, 3};
    tbl[3] = '{1, 0, 1, 0, 1, 1, 0, 3};
    tbl[4] = '{0, 0, 1, 0, 1, 1, 1, 2};
    tbl[5] = '{0, 0, 1, 0, 1, 1, 2, 1};
    tbl[6] = '{0, 0, 1, 0, 1, 1, 3, 0};
    tbl[7] = '{0, 0, 1, 0, 1, 0, 0, 0};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_skip", out_skip, 0);
    chk("rst_err_late", err_late, 0);
    chk("rst_err_dup", err_dup, 0);
    chk("rst_occupancy", occupancy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 32; k++) begin
      cycle(1, k, 1, 0);
      chk("inorder_addr", out_addr, k);
      chk("inorder_occ", occupancy, 0);
    end
    idle(1, 1);

    cycle(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].ordy, tbl[i].clr);
      chk("tbl_rdy", last_rdy, tbl[i].e_rdy);
      chk("tbl_ov", out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk("tbl_oa", out_addr, tbl[i].e_oa);
      chk("tbl_occ", occupancy, tbl[i].e_occ);
    end

    // Window edge: addr 16 waits until addr 0 has been emitted.
    cycle(0, 0, 1, 1);
    cycle(1, 16, 1, 0);
    chk("win_far", last_rdy, 0);
    for (int k = 1; k < 16; k++) cycle(1, k, 1, 0);
    cycle(1, 16, 1, 0);
    chk("win_still_far", last_rdy, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 16, 1, 0);
    chk("win_open", last_rdy, 1);
    idle(20, 1);

    // Duplicate then late beat.
    cycle(0, 0, 1, 1);
    late_seen = 0; dup_seen = 0;
    cycle(1, 5, 1, 0);
    cycle(1, 5, 1, 0);
    for (int k = 0; k < 5; k++) cycle(1, k, 1, 0);
    idle(4, 1);
    cycle(1, 2, 1, 0);
    idle(2, 1);
    chk("dup_pulses", dup_seen, 1);
    chk("late_pulses", late_seen, 1);

    // Backpressure: output holds addr 0 while 1..9 fill the RAM.
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 10; k++) cycle(1, k, 0, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_addr", out_addr, 0);
    chk("bp_hold_occ", occupancy, 9);
    for (int k = 1; k < 10; k++) begin
      cycle(0, 0, 1, 0);
      chk("bp_release_addr", out_addr, k);
      chk("bp_release_valid", out_valid, 1);
    end
    cycle(0, 0, 1, 0);
    chk("bp_drained", out_valid, 0);

    // Clear mid-stream.
    cycle(0, 0, 1, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 3, 0, 0);
    cycle(1, 4, 0, 0);
    chk("pre_clear_occ", occupancy, 2);
    cycle(0, 0, 0, 1);
    chk("clear_valid", out_valid, 0);
    chk("clear_occ", occupancy, 0);

    // Wrap-around 255 -> 0 with a reordered pair on each side.
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 254; k++) cycle(1, k, 1, 0);
    cycle(1, 255, 1, 0);
    cycle(1, 1, 1, 0);
    cycle(1, 254, 1, 0);
    cycle(1, 0, 1, 0);
    idle(3, 1);
    chk("wrap_last_addr", out_addr, 1);

`ifdef REORDER_TIMEOUT_EN
    begin
      bit found;
      cycle(0, 0, 1, 1);
      cycle(1, 1, 1, 0);
      cycle(1, 2, 1, 0);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
        cycle(0, 0, 1, 0);
        if (out_valid && out_skip) found = 1;
      end
      chk("to_skip_seen", found, 1);
      if (found) begin
        chk("to_skip_addr", out_addr, 0);
        chk("to_skip_data", out_data, FILL);
        cycle(0, 0, 1, 0);
        chk("to_next_addr1", out_addr, 1);
        cycle(0, 0, 1, 0);
        chk("to_next_addr2", out_addr, 2);
      end
      late_seen = 0;
      cycle(1, 0, 1, 0);
      idle(1, 1);
      chk("to_late_skipped", late_seen, 1);
    end
`endif

    // Randomized traffic around the current head, with occasional clears.
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 4000; i++) begin
      int r, a;
      bit v, ordy, clr;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 1499) == 0);
      r    = $urandom_range(0, 99);
      if (r < 30)      a = m_exp;
      else if (r < 40) a = m_exp - int'($urandom_range(1, 3));
      else             a = m_exp + int'($urandom_range(1, DP + 3));
      cycle(v, a, ordy, clr);
    end
    idle(40, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Parametrised reorder stage for pixel streams. Accepts (data, addr) beats in any order within a sliding window of DEPTH addresses, and emits them strictly in ascending address order.
- Sits between the out-of-order renderer/memory return path and the display/framebuffer writer.
- Improves on the first-generation sorter with:
  - generic width and depth
  - full address tracking and wrap-around
  - input/output valid-ready backpressure
  - late and duplicate detection
  - a synchronous frame clear

Parameters:
DATA_W, 24, payload width
ADDR_W, 20, pixel address width; the sequence counter wraps modulo 2^ADDR_W
DEPTH, 16, window/buffer entries; power of two, 2..256, DEPTH < 2^(ADDR_W-1)
TIMEOUT, 1024, stall cycles before head skip (used only with REORDER_TIMEOUT_EN)
FILL_VALUE, 0, payload emitted for a skipped address

Ports:
clk  in  1  clock; one clock domain
rst_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush, start of new frame
in_data  in  DATA_W  payload
in_addr  in  ADDR_W  payload address
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
out_data  out  DATA_W  in-order payload
out_addr  out  ADDR_W  address of out_data
out_valid  out  1  output valid
out_ready  in  1  downstream ready
out_skip  out  1  out_data is FILL_VALUE substituted for a missing address
err_late  out  1  one-cycle pulse: stale beat dropped
err_dup  out  1  one-cycle pulse: duplicate beat dropped
occupancy  out  $clog2(DEPTH)+1  count of buffered entries, excluding the output register

Behaviour:
- Reset (rst_n low, async):
  - exp_addr = 0 (next address to emit); valid flags all 0.
  - Outputs: out_valid=0, out_data=0, out_addr=0, out_skip=0, err_*=0, occupancy=0.
  - Storage RAM is not reset.
- Index and offset:
  - slot = addr[$clog2(DEPTH)-1:0]
  - off = (in_addr - exp_addr) mod 2^ADDR_W
- Input classification. in_ready is combinational from in_addr, state and clear:
  - off < DEPTH, slot empty: in_ready=1, beat stored (or bypassed, see below).
  - off < DEPTH, slot occupied: in_ready=1, beat dropped, err_dup pulses the next cycle.
  - off >= 2^(ADDR_W-1) (behind the window): in_ready=1, beat dropped, err_late pulses the next cycle.
  - Otherwise (too far ahead): in_ready=0, stall until the window advances.
  - clear=1: in_ready=0.
- Output register:
  - Loads when (!out_valid || out_ready) and the head is available.
  - Head is available when valid[exp_addr slot] is set, or an accepted input this cycle has in_addr == exp_addr (bypass path, not written to RAM).
  - On load: out_addr=exp_addr; exp_addr increments (wrapping); the head flag is cleared.
  - Latency from input to output is 1 cycle when in order.
  - Sustained throughput is 1 beat/cycle.
- out_valid && !out_ready: output fields hold stable; in-order input still fills RAM while the window permits.
- Simultaneous events:
  - A head load and a RAM write to a different slot in the same cycle are both performed.
  - occupancy = previous + writes − head-from-RAM loads.
- clear:
  - Valid flags are zeroed; exp_addr=0; out_valid=0.
  - clear takes priority over any load or write that cycle.
  - err_* are not asserted by beats arriving while clear=1, since they are not accepted.
- Wrap-around: exp_addr 2^ADDR_W−1 → 0 is seamless; window arithmetic is modular.

Optional Feature:
- REORDER_TIMEOUT_EN defined:
  - A counter increments each cycle in which occupancy>0, the head is unavailable and the output register can load. It resets on any load or clear.
  - At TIMEOUT the block loads out_data=FILL_VALUE, out_addr=exp_addr and out_skip=1, then advances exp_addr.
  - A beat for the skipped address that arrives later is classified late.
- Undefined: no counter is present; out_skip is tied 0; a missing address stalls forever until clear.

Test Plan:
- Reset release, then addr 0..31 in order with out_ready=1 → out_addr 0..31 one cycle after each input, occupancy stays 0, no errors.
- Addrs 3,1,2,0 (DEPTH=16) → outputs 0,1,2,3 on consecutive cycles starting the cycle after addr 0 is accepted; occupancy peaks at 3.
- exp_addr=0, in_addr=16 → in_ready=0; then feed 0..15 → in_ready for addr 16 rises once exp_addr=1.
- Send addr 5 twice before 0..4, then later resend addr 2 after it has been emitted → err_dup pulses once and err_late pulses once; the output sequence is unaffected.
- Hold out_ready=0 for 10 cycles with 0..9 in order → out_addr holds 0, occupancy=9; release → 1..9 follow back-to-back.
- REORDER_TIMEOUT_EN with TIMEOUT=8: send 1,2 but never 0 → after 8 stall cycles outputs addr 0 with out_skip=1 and data FILL_VALUE, then addrs 1,2. Also drive clear mid-stream → out_valid=0 and occupancy=0 the next cycle.
